// File: rtl/delay_sum_tx_pkg.sv
// Shared types and width helpers for the delay-and-sum transmitter.
package delay_sum_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDly,
    StSmp,
    StAcc,
    StTx,
    StFin
  } state_e;

  // Address/index width, never zero so single-entry tables still get a 1-bit port.
  function automatic int unsigned clog2_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned sum_width(input int unsigned smp_w, input int unsigned n_ch);
    return smp_w + ((n_ch > 1) ? $clog2(n_ch) : 0);
  endfunction

  function automatic int unsigned nb_bytes(input int unsigned sum_w);
    return (sum_w + 7) / 8;
  endfunction

endpackage

// File: rtl/delay_sum_tx_byte_serializer.sv
// NB-byte MSB-first shifter; strobes one byte per ready cycle with a mandatory idle cycle after
// each strobe so the transmitter has time to drop its ready.
module delay_sum_tx_byte_serializer
  import delay_sum_tx_pkg::*;
#(
  parameter int unsigned NB = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [NB*8-1:0] data_i,
  input  logic            active_i,
  input  logic            tx_rdy_i,
  output logic            tx_en_o,
  output logic [7:0]      tx_data_o,
  output logic            last_o
);

  localparam int unsigned BW = clog2_w(NB);

  logic [NB*8-1:0] sh_q, sh_d;
  logic [BW-1:0]   b_q, b_d;
  logic            gap_q, gap_d;

  always_comb begin
    tx_en_o   = active_i && tx_rdy_i && !gap_q;
    tx_data_o = tx_en_o ? sh_q[NB*8-1 -: 8] : 8'h00;
    last_o    = tx_en_o && (b_q == BW'(NB - 1));
    sh_d      = sh_q;
    b_d       = b_q;
    gap_d     = tx_en_o;
    if (load_i) begin
      sh_d = data_i;
      b_d  = '0;
    end else if (tx_en_o) begin
      sh_d = sh_q << 8;
      b_d  = b_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      b_q   <= '0;
      gap_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      b_q   <= b_d;
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/delay_sum_tx.sv
// Delay-and-sum frame engine: for each output, fetches N_CH delayed samples through the delay
// table, accumulates them and ships the sum MSB-first over a byte-wide handshake.
module delay_sum_tx
  import delay_sum_tx_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned N_OUT = 768,
  parameter int unsigned SMP_W = 32,
  parameter int unsigned AW    = 13
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              signed_mode,
  output logic                              dly_rd_en,
  output logic [clog2_w(N_CH*N_OUT)-1:0]    dly_rd_addr,
  input  logic [AW-1:0]                     dly_rd_data,
  output logic                              smp_rd_en,
  output logic [AW-1:0]                     smp_rd_addr,
  input  logic [SMP_W-1:0]                  smp_rd_data,
  output logic [7:0]                        tx_data,
  output logic                              tx_en,
  input  logic                              tx_rdy,
  output logic                              busy,
  output logic                              done,
  output logic [clog2_w(N_OUT)-1:0]         out_idx
);

  localparam int unsigned DAW   = clog2_w(N_CH * N_OUT);
  localparam int unsigned OW    = clog2_w(N_OUT);
  localparam int unsigned CW    = clog2_w(N_CH);
  localparam int unsigned SUM_W = sum_width(SMP_W, N_CH);
  localparam int unsigned NB    = nb_bytes(SUM_W);
  localparam int unsigned EXT_W = NB * 8;

  state_e            state_q, state_d;
  logic [CW-1:0]     c_q, c_d;
  logic [OW-1:0]     t_q, t_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic              sm_q, sm_d;

  logic [SUM_W-1:0]  smp_ext;
  logic [SUM_W-1:0]  acc_sum;
  logic [EXT_W-1:0]  acc_ext;
  logic              ser_load;
  logic              ser_last;

  // Datapath: extend the incoming sample, add, then widen the sum to whole bytes.
  always_comb begin
    if (sm_q) begin
      smp_ext = SUM_W'($signed(smp_rd_data));
    end else begin
      smp_ext = SUM_W'(smp_rd_data);
    end
    acc_sum = acc_q + smp_ext;
    if (sm_q) begin
      acc_ext = EXT_W'($signed(acc_sum));
    end else begin
      acc_ext = EXT_W'(acc_sum);
    end
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    t_d      = t_q;
    acc_d    = acc_q;
    sm_d     = sm_q;
    ser_load = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sm_d    = signed_mode;
            t_d     = '0;
            c_d     = '0;
            acc_d   = '0;
            state_d = StDly;
          end
        end
        StDly: state_d = StSmp;
        StSmp: state_d = StAcc;
        StAcc: begin
          acc_d = acc_sum;
          if (c_q != CW'(N_CH - 1)) begin
            c_d     = c_q + 1'b1;
            state_d = StDly;
          end else begin
            ser_load = 1'b1;
            state_d  = StTx;
          end
        end
        StTx: begin
          if (ser_last) begin
            if (t_q != OW'(N_OUT - 1)) begin
              t_d     = t_q + 1'b1;
              c_d     = '0;
              acc_d   = '0;
              state_d = StDly;
            end else begin
              state_d = StFin;
            end
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decode from registered state so reset clears them without a clock.
  always_comb begin
    dly_rd_en   = (state_q == StDly);
    dly_rd_addr = dly_rd_en ? (DAW'(c_q) * DAW'(N_OUT) + DAW'(t_q)) : '0;
    smp_rd_en   = (state_q == StSmp);
    smp_rd_addr = smp_rd_en ? dly_rd_data : '0;
    busy        = (state_q != StIdle);
    done        = (state_q == StFin);
    out_idx     = t_q;
  end

  delay_sum_tx_byte_serializer #(
    .NB (NB)
  ) u_ser (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (ser_load),
    .data_i    (acc_ext),
    .active_i  (state_q == StTx),
    .tx_rdy_i  (tx_rdy),
    .tx_en_o   (tx_en),
    .tx_data_o (tx_data),
    .last_o    (ser_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      c_q     <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      sm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      sm_q    <= sm_d;
    end
  end

endmodule

// File: tb/tb_delay_sum_tx.sv
// Bench for delay_sum_tx: RAM models, a strobe monitor and an arithmetic reference of each sum.
module tb_delay_sum_tx;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned SMP_W = 32;
  localparam int unsigned AW    = 13;
  localparam int unsigned NB    = 5;   // 35-bit sum
  localparam int unsigned DAW   = 5;
  localparam int unsigned OW    = 2;
  localparam int unsigned NB1   = 4;   // single channel: 32-bit sum

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, signed_mode, tx_rdy;
  logic dly_rd_en, smp_rd_en, tx_en, busy, done;
  logic [DAW-1:0] dly_rd_addr;
  logic [AW-1:0] dly_rd_data, smp_rd_addr;
  logic [SMP_W-1:0] smp_rd_data;
  logic [7:0] tx_data;
  logic [OW-1:0] out_idx;

  logic start1, abort1, sm1, tx_rdy1;
  logic dly_rd_en1, smp_rd_en1, tx_en1, busy1, done1;
  logic [0:0] dly_rd_addr1, out_idx1;
  logic [AW-1:0] dly_rd_data1, smp_rd_addr1;
  logic [SMP_W-1:0] smp_rd_data1;
  logic [7:0] tx_data1;

  logic [AW-1:0] dly_mem [N_CH*N_OUT];
  logic [SMP_W-1:0] smp_mem [2**AW];
  logic [AW-1:0] dly1_word;

  delay_sum_tx #(.N_CH(N_CH), .N_OUT(N_OUT), .SMP_W(SMP_W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .signed_mode(signed_mode),
    .dly_rd_en(dly_rd_en), .dly_rd_addr(dly_rd_addr), .dly_rd_data(dly_rd_data),
    .smp_rd_en(smp_rd_en), .smp_rd_addr(smp_rd_addr), .smp_rd_data(smp_rd_data),
    .tx_data(tx_data), .tx_en(tx_en), .tx_rdy(tx_rdy),
    .busy(busy), .done(done), .out_idx(out_idx)
  );

  delay_sum_tx #(.N_CH(1), .N_OUT(1), .SMP_W(SMP_W), .AW(AW)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .signed_mode(sm1),
    .dly_rd_en(dly_rd_en1), .dly_rd_addr(dly_rd_addr1), .dly_rd_data(dly_rd_data1),
    .smp_rd_en(smp_rd_en1), .smp_rd_addr(smp_rd_addr1), .smp_rd_data(smp_rd_data1),
    .tx_data(tx_data1), .tx_en(tx_en1), .tx_rdy(tx_rdy1),
    .busy(busy1), .done(done1), .out_idx(out_idx1)
  );

  // Synchronous-read RAMs with one cycle of latency.
  always @(posedge clk) begin
    if (dly_rd_en) dly_rd_data <= dly_mem[dly_rd_addr];
    if (smp_rd_en) smp_rd_data <= smp_mem[smp_rd_addr];
    if (dly_rd_en1) dly_rd_data1 <= dly1_word;
    if (smp_rd_en1) smp_rd_data1 <= smp_mem[smp_rd_addr1];
  end

  logic [7:0] sb_q[$];
  int unsigned si_q[$];
  int unsigned da_q[$];
  int unsigned cyc = 0, done_cnt = 0, done_cyc = 0, last_strobe_cyc = 0, b2b = 0;
  int unsigned last_reads = 0, pre_run = 0, pre_lat = 0;
  bit in_pre = 1'b1, prev_en = 1'b0;
  logic [7:0] sb1_q[$];
  int unsigned done1_cnt = 0, dly1_reads = 0, pre1_run = 0, pre1_lat = 0;
  bit in1_pre = 1'b1;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    prev_en <= tx_en;
    if (tx_en && prev_en) b2b <= b2b + 1;
    if (tx_en) begin
      sb_q.push_back(tx_data);
      si_q.push_back(int'(out_idx));
      last_strobe_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (dly_rd_en) begin
      da_q.push_back(int'(dly_rd_addr));
      if (dly_rd_addr == DAW'(N_CH * N_OUT - 1)) last_reads <= last_reads + 1;
    end
    if (!busy) begin
      in_pre  <= 1'b1;
      pre_run <= 0;
    end else if (in_pre) begin
      if (tx_en) begin
        pre_lat <= pre_run;
        in_pre  <= 1'b0;
      end else begin
        pre_run <= pre_run + 1;
      end
    end
    if (tx_en1) sb1_q.push_back(tx_data1);
    if (done1) done1_cnt <= done1_cnt + 1;
    if (dly_rd_en1 && dly_rd_addr1 == 1'b0) dly1_reads <= dly1_reads + 1;
    if (!busy1) begin
      in1_pre  <= 1'b1;
      pre1_run <= 0;
    end else if (in1_pre) begin
      if (tx_en1) begin
        pre1_lat <= pre1_run;
        in1_pre  <= 1'b0;
      end else begin
        pre1_run <= pre1_run + 1;
      end
    end
  end

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum of the delayed samples, viewed as two's complement bits.
  function automatic logic [63:0] model_sum(input int unsigned t, input bit sm);
    longint s;
    logic [SMP_W-1:0] v;
    s = 0;
    for (int c = 0; c < N_CH; c++) begin
      v = smp_mem[dly_mem[c * N_OUT + t]];
      if (sm) s += longint'($signed(v));
      else s += longint'(v);
    end
    return s;
  endfunction

  function automatic logic [7:0] model_byte(input int unsigned t, input int unsigned k,
                                            input bit sm);
    logic [63:0] u;
    u = model_sum(t, sm);
    return u[8 * (NB - 1 - k) +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready held low well into TX, then random.
  task automatic run_frame(input bit sm, input int mode, input bit spam,
                           output int unsigned base);
    int unsigned b0, d0, a0, lr0, nbytes;
    b0 = sb_q.size();
    d0 = done_cnt;
    a0 = da_q.size();
    lr0 = last_reads;
    base = b0;
    signed_mode = sm;
    tx_rdy = (mode == 0);
    pulse_start();
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      if (mode == 1) begin
        if (i == 3 * N_CH + 50) check("hold_no_strobe", sb_q.size() - b0, 0);
        if (i < 3 * N_CH + 50) tx_rdy = 1'b0;
        else tx_rdy = 1'($urandom_range(0, 1));
      end
      start = spam && (i == 3 || i == 40);
      step();
    end
    start = 1'b0;
    tx_rdy = 1'b1;
    step();
    step();
    step();
    check("done_once", done_cnt - d0, 1);
    check("idle_after", busy, 1'b0);
    nbytes = sb_q.size() - b0;
    check("byte_count", nbytes, N_OUT * NB);
    for (int k = 0; k < N_OUT * NB && k < nbytes; k++) begin
      check($sformatf("byte%0d", k), sb_q[b0 + k], model_byte(k / NB, k % NB, sm));
      check($sformatf("idx%0d", k), si_q[b0 + k], k / NB);
    end
    check("last_addr_once", last_reads - lr0, 1);
    if (da_q.size() > a0) check("first_dly_addr", da_q[a0], 0);
    else check("first_dly_addr_seen", da_q.size() - a0, 1);
    if (mode == 0) begin
      check("latency_to_tx", pre_lat, 3 * N_CH);
      check("done_after_last", done_cyc - last_strobe_cyc, 1);
    end
  endtask

  initial begin
    int unsigned b0, d0, bb, d1, b1, r1;
    bit found;
    logic [7:0] exp5 [5];
    logic [31:0] w;

    reset = 1'b1; start = 1'b0; abort = 1'b0; signed_mode = 1'b0; tx_rdy = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; sm1 = 1'b0; tx_rdy1 = 1'b1;
    for (int a = 0; a < 2**AW; a++) smp_mem[a] = SMP_W'(a);
    for (int c = 0; c < N_CH; c++)
      for (int t = 0; t < N_OUT; t++) dly_mem[c * N_OUT + t] = AW'(c * 16 + t);
    dly1_word = AW'(5);

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_dly_en", dly_rd_en, 1'b0);
    check("rst_dly_addr", dly_rd_addr, '0);
    check("rst_smp_en", smp_rd_en, 1'b0);
    check("rst_smp_addr", smp_rd_addr, '0);
    check("rst_out_idx", out_idx, '0);
    step();
    reset = 1'b0;
    step();
    step();

    // Ramp pattern: output 0 sums c*16 over eight channels = 448.
    run_frame(1'b0, 0, 1'b0, b0);
    exp5 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hC0};
    for (int k = 0; k < 5; k++) check($sformatf("ramp_t0_b%0d", k), sb_q[b0 + k], exp5[k]);

    for (int a = 0; a < 2**AW; a++) smp_mem[a] = '1;
    run_frame(1'b1, 0, 1'b0, b0);
    exp5 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8};
    for (int k = 0; k < 5; k++) check($sformatf("neg8_b%0d", k), sb_q[b0 + k], exp5[k]);
    // 8 * 0xFFFFFFFF = 0x7_FFFF_FFF8
    run_frame(1'b0, 0, 1'b0, b0);
    exp5 = '{8'h07, 8'hFF, 8'hFF, 8'hFF, 8'hF8};
    for (int k = 0; k < 5; k++) check($sformatf("ones_u_b%0d", k), sb_q[b0 + k], exp5[k]);

    for (int a = 0; a < 2**AW; a++) smp_mem[a] = $urandom;
    for (int i = 0; i < N_CH * N_OUT; i++) dly_mem[i] = AW'($urandom_range(0, 2**AW - 1));
    run_frame(1'b1, 0, 1'b0, b0);
    run_frame(1'b0, 0, 1'b0, b0);

    run_frame(1'($urandom_range(0, 1)), 1, 1'b0, b0);

    // Abort in the accumulate cycle of output 2.
    signed_mode = 1'b0;
    d0 = done_cnt;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (out_idx == OW'(2) && smp_rd_en) found = 1'b1;
      else step();
    end
    check("abort_reached_t2", found, 1'b1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", busy, 1'b0);
    check("abort_no_dly", dly_rd_en, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_stays_idle", busy, 1'b0);
    run_frame(1'b0, 0, 1'b0, b0);

    // Reset in the middle of a TX strobe.
    bb = sb_q.size();
    pulse_start();
    for (int i = 0; i < 500 && sb_q.size() < bb + 6; i++) step();
    step();
    check("pre_reset_tx_en", tx_en, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_tx_en", tx_en, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_out_idx", out_idx, '0);
    check("mid_rst_dly_en", dly_rd_en, 1'b0);
    check("mid_rst_dly_addr", dly_rd_addr, '0);
    check("mid_rst_smp_en", smp_rd_en, 1'b0);
    check("mid_rst_smp_addr", smp_rd_addr, '0);
    check("mid_rst_done", done, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();
    run_frame(1'b1, 0, 1'b1, b0);

    // Single-channel, single-output instance.
    d1 = done1_cnt;
    b1 = sb1_q.size();
    r1 = dly1_reads;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 200 && done1_cnt == d1; i++) step();
    step();
    step();
    check("n1_done_once", done1_cnt - d1, 1);
    check("n1_idle", busy1, 1'b0);
    check("n1_out_idx", out_idx1, 1'b0);
    check("n1_latency", pre1_lat, 3);
    check("n1_addr_once", dly1_reads - r1, 1);
    check("n1_byte_count", sb1_q.size() - b1, NB1);
    w = smp_mem[dly1_word];
    for (int k = 0; k < NB1 && b1 + k < sb1_q.size(); k++)
      check($sformatf("n1_byte%0d", k), sb1_q[b1 + k], w[8 * (NB1 - 1 - k) +: 8]);

    check("no_back_to_back", b2b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
